// File: rtl/agc_gain_stage.sv
// rtl/agc_gain_stage.sv - RFDC 8x16b gain/offset/round/saturate stage with windowed power stats
// Optional saturation statistics: define AGC_SAT_COUNT_EN.
module agc_gain_stage #(
  parameter int WIN_BITS = 20,
  parameter int ACC_BITS = 48
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [127:0]        s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [127:0]        m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [15:0]         gain_i,
  input  logic [15:0]         offset_i,
  input  logic                update_i,
  input  logic [WIN_BITS-1:0] window_len_i,
  output logic [ACC_BITS-1:0] sq_sum_o,
  output logic [23:0]         sat_count_o,
  output logic                stats_valid_o
);

  logic advance, accept, out_hs;
  assign advance       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = advance;
  assign accept        = s_axis_tvalid && advance;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  logic [15:0]         pend_gain, pend_off, act_gain, act_off, eff_gain, eff_off;
  logic [WIN_BITS-1:0] win_cnt, win_last, len_m1, cur_last;
  logic                win_first, beat_last;

  // A window's first beat picks up pending (or same-cycle) settings; later beats reuse them.
  always_comb begin
    win_first = (win_cnt == '0);
    len_m1    = (window_len_i == '0) ? '0 : window_len_i - WIN_BITS'(1);
    cur_last  = win_first ? len_m1 : win_last;
    beat_last = (win_cnt == cur_last);
    eff_gain  = act_gain;
    eff_off   = act_off;
    if (win_first) begin
      eff_gain = update_i ? gain_i : pend_gain;
      eff_off  = update_i ? offset_i : pend_off;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend_gain <= 16'h1000;
      pend_off  <= '0;
      act_gain  <= 16'h1000;
      act_off   <= '0;
      win_cnt   <= '0;
      win_last  <= '0;
    end else begin
      if (update_i) begin
        pend_gain <= gain_i;
        pend_off  <= offset_i;
      end
      if (accept) begin
        if (win_first) begin
          act_gain <= eff_gain;
          act_off  <= eff_off;
          win_last <= len_m1;
        end
        win_cnt <= beat_last ? '0 : win_cnt + WIN_BITS'(1);
      end
    end
  end

  logic               v1, v2, last1, last2, last3;
  logic signed [32:0] p1 [8];
  logic signed [15:0] off1;
  logic signed [22:0] r2 [8];
  logic signed [22:0] r_next [8];
  logic signed [34:0] q;
  logic [127:0]       y_next;
`ifdef AGC_SAT_COUNT_EN
  logic [3:0]         nsat, sat3;
`endif

  always_comb begin
    y_next = '0;
    q      = '0;
`ifdef AGC_SAT_COUNT_EN
    nsat   = '0;
`endif
    for (int k = 0; k < 8; k++) begin
      q         = 35'(p1[k]) + (35'(off1) <<< 12) + 35'sd2048;
      r_next[k] = 23'(q >>> 12);
      if (r2[k] > 23'sd32767) begin
        y_next[16*k +: 16] = 16'h7FFF;
`ifdef AGC_SAT_COUNT_EN
        nsat = nsat + 4'd1;
`endif
      end else if (r2[k] < -23'sd32768) begin
        y_next[16*k +: 16] = 16'h8000;
`ifdef AGC_SAT_COUNT_EN
        nsat = nsat + 4'd1;
`endif
      end else begin
        y_next[16*k +: 16] = r2[k][15:0];
      end
    end
  end

  // Global stall: every stage moves only when the output slot is free.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      last1         <= 1'b0;
      last2         <= 1'b0;
      last3         <= 1'b0;
      off1          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      for (int k = 0; k < 8; k++) begin
        p1[k] <= '0;
        r2[k] <= '0;
      end
`ifdef AGC_SAT_COUNT_EN
      sat3          <= '0;
`endif
    end else if (advance) begin
      v1            <= s_axis_tvalid;
      last1         <= beat_last;
      off1          <= eff_off;
      v2            <= v1;
      last2         <= last1;
      m_axis_tvalid <= v2;
      last3         <= last2;
      m_axis_tdata  <= y_next;
      for (int k = 0; k < 8; k++) begin
        p1[k] <= 33'($signed(s_axis_tdata[16*k +: 16])) * 33'($signed({1'b0, eff_gain}));
        r2[k] <= r_next[k];
      end
`ifdef AGC_SAT_COUNT_EN
      sat3          <= nsat;
`endif
    end
  end

  logic [25:0]         beat_sq;
  logic signed [23:0]  s_ext, s_sq;
  logic [ACC_BITS-1:0] acc, acc_next;

  // Power uses the top 12 bits of each output sample so 8 squares per beat stay small.
  always_comb begin
    beat_sq = '0;
    s_ext   = '0;
    s_sq    = '0;
    for (int k = 0; k < 8; k++) begin
      s_ext   = 24'($signed(m_axis_tdata[16*k+4 +: 12]));
      s_sq    = s_ext * s_ext;
      beat_sq = beat_sq + 26'($unsigned(s_sq));
    end
    acc_next = acc + ACC_BITS'(beat_sq);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc           <= '0;
      sq_sum_o      <= '0;
      stats_valid_o <= 1'b0;
    end else begin
      stats_valid_o <= 1'b0;
      if (out_hs) begin
        if (last3) begin
          sq_sum_o      <= acc_next;
          acc           <= '0;
          stats_valid_o <= 1'b1;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

`ifdef AGC_SAT_COUNT_EN
  logic [23:0] sat_acc;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sat_acc     <= '0;
      sat_count_o <= '0;
    end else if (out_hs) begin
      if (last3) begin
        sat_count_o <= sat_acc + 24'(sat3);
        sat_acc     <= '0;
      end else begin
        sat_acc <= sat_acc + 24'(sat3);
      end
    end
  end
`else
  assign sat_count_o = '0;
`endif

endmodule

// File: tb/tb_agc_gain_stage.sv
// tb/tb_agc_gain_stage.sv - scoreboard bench for agc_gain_stage with arithmetic reference model
module tb_agc_gain_stage;
  localparam int WIN_BITS = 20;
  localparam int ACC_BITS = 48;

  logic                aclk = 1'b0;
  logic                areset;
  logic [127:0]        s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [127:0]        m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [15:0]         gain_i;
  logic [15:0]         offset_i;
  logic                update_i;
  logic [WIN_BITS-1:0] window_len_i;
  logic [ACC_BITS-1:0] sq_sum_o;
  logic [23:0]         sat_count_o;
  logic                stats_valid_o;

  always #5 aclk = ~aclk;

  agc_gain_stage #(.WIN_BITS(WIN_BITS), .ACC_BITS(ACC_BITS)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .gain_i(gain_i), .offset_i(offset_i), .update_i(update_i), .window_len_i(window_len_i),
    .sq_sum_o(sq_sum_o), .sat_count_o(sat_count_o), .stats_valid_o(stats_valid_o)
  );

  typedef struct { logic [127:0] data; bit last; } beat_t;
  typedef struct { longint sq; int sat; } stat_t;

  beat_t  exp_q[$];
  stat_t  st_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     first_acc = -1;
  int     first_val = -1;
  int     stall_cnt = 0;
  bit     rand_rdy = 0;
  bit     exp_sv = 0;
  bit     held = 0;
  logic [127:0] held_data;

  int     m_idx = 0, m_len = 1;
  int     m_pend_gain = 4096, m_pend_off = 0, m_act_gain = 4096, m_act_off = 0;
  longint m_sq = 0;
  int     m_sat = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input int x, input int g, input int off, output bit sat);
    longint q, r;
    q   = longint'(x) * longint'(g) + longint'(off) * 4096 + 2048;
    r   = q >>> 12;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return r[15:0];
  endfunction

  // Reference model, scoreboard and monitors, all sampled on the falling edge.
  initial begin
    beat_t b, e;
    stat_t st, es;
    bit    sat, nxt_sv;
    int    x, y;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        exp_q.delete(); st_q.delete();
        m_idx = 0; m_len = 1; m_pend_gain = 4096; m_pend_off = 0;
        m_act_gain = 4096; m_act_off = 0; m_sq = 0; m_sat = 0;
        exp_sv = 0; held = 0;
        continue;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (first_acc < 0) first_acc = cyc;
        if (m_idx == 0) begin
          m_len      = (window_len_i == 0) ? 1 : int'(window_len_i);
          m_act_gain = update_i ? int'(gain_i) : m_pend_gain;
          m_act_off  = update_i ? int'($signed(offset_i)) : m_pend_off;
        end
        b.data = '0;
        for (int k = 0; k < 8; k++) begin
          x = int'($signed(s_axis_tdata[16*k +: 16]));
          b.data[16*k +: 16] = model_sample(x, m_act_gain, m_act_off, sat);
          y = int'($signed(b.data[16*k +: 16]));
          m_sq  += longint'((y >>> 4) * (y >>> 4));
          m_sat += int'(sat);
        end
        b.last = (m_idx == m_len - 1);
        exp_q.push_back(b);
        if (b.last) begin
          st.sq = m_sq; st.sat = m_sat;
          st_q.push_back(st);
          m_sq = 0; m_sat = 0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (update_i) begin
        m_pend_gain = int'(gain_i);
        m_pend_off  = int'($signed(offset_i));
      end
      chk("stats_timing", stats_valid_o, exp_sv);
      if (stats_valid_o) begin
        if (st_q.size() == 0) chk("stats_unexpected", 1, 0);
        else begin
          es = st_q.pop_front();
          chk("sq_sum", sq_sum_o, es.sq);
`ifdef AGC_SAT_COUNT_EN
          chk("sat_count", sat_count_o, es.sat);
`else
          chk("sat_count", sat_count_o, 0);
`endif
        end
      end
      nxt_sv = 0;
      if (m_axis_tvalid) begin
        if (first_val < 0) first_val = cyc;
        if (held) chk("hold_stable", m_axis_tdata, held_data);
        if (!m_axis_tready) chk("tready_stall", s_axis_tready, 0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e.data);
          nxt_sv = e.last;
        end
      end
      held      = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      exp_sv    = nxt_sv;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (stall_cnt > 0) begin m_axis_tready = 1'b0; stall_cnt--; end
      else if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
      else m_axis_tready = 1'b1;
    end
  end

  task automatic send(input logic [127:0] d, input bit upd, input logic [15:0] g, input logic [15:0] o);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    update_i      = upd;
    if (upd) begin gain_i = g; offset_i = o; end
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      guard++;
      if (guard > 1000) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    update_i      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic align();
    int n;
    n = 0;
    while (m_idx != 0 && n < 64) begin send('0, 0, 0, 0); n++; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0 || exp_sv) && n < 500) begin
      @(posedge aclk); n++;
    end
    #1;
    chk("drain_empty", exp_q.size() + st_q.size(), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_sq_sum", sq_sum_o, 0);
    chk("rst_sat_count", sat_count_o, 0);
    chk("rst_stats_valid", stats_valid_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d;
    areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    gain_i = '0; offset_i = '0; update_i = 1'b0; window_len_i = 4;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_state();
    areset = 1'b0;
    idle(1);

    // unity gain ramp and first-beat latency
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) d[16*k +: 16] = 16'(i * 8 + k);
      send(d, 0, 0, 0);
    end
    idle(6);
    chk("latency", 32'(first_val - first_acc), 3);

    // saturation, half gain rounding, offset
    align();
    window_len_i = 1;
    d = '0; d[15:0] = 16'h5000; d[31:16] = 16'hB000;
    send(d, 1, 16'h2000, 16'h0000);
    d = '0; d[15:0] = 16'd3; d[31:16] = 16'hFFFD;
    send(d, 1, 16'h0800, 16'h0000);
    d = '0; d[15:0] = 16'd10;
    send(d, 1, 16'h1000, 16'd5);
    send({8{16'h8000}}, 1, 16'h1000, 16'hFFFB);

    // window of 4 with constant 0x0100 samples
    window_len_i = 4;
    send({8{16'h0100}}, 1, 16'h1000, 16'h0000);
    for (int i = 0; i < 7; i++) send({8{16'h0100}}, 0, 0, 0);

    // five-cycle output stall with continuous input
    for (int i = 0; i < 12; i++) begin
      if (i == 4) stall_cnt = 5;
      send({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    end

    // mid-window gain update takes effect on the next window
    align();
    for (int i = 0; i < 12; i++) send({8{16'h0400}}, i == 2, 16'h2000, 16'h0000);

    // randomized traffic
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) window_len_i = WIN_BITS'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) d = d >> $urandom_range(0, 120);
      send(d, $urandom_range(0, 6) == 0, 16'($urandom_range(0, 16'h3000)), 16'($urandom));
    end
    align();
    rand_rdy = 0;
    drain();

    // reset with beats in flight and a partial window
    window_len_i = 4;
    send({8{16'h1234}}, 0, 0, 0);
    send({8{16'h4321}}, 0, 0, 0);
    areset = 1'b1;
    idle(2);
    check_reset_state();
    areset = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send({8{16'(16'h0100 * (i + 1))}}, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/agc_gain_stage.md
# agc_gain_stage

Per-channel gain/offset stage on one 128-bit RFDC ADC AXI4-Stream (8 × 16-bit signed samples per beat), placed between the RFDC master stream and the downstream buffer/trigger logic inside the AGC design. Each sample is multiplied by a programmable gain, offset, rounded and saturated. The block also accumulates per-window power (sum of squares) and saturation statistics, which the AGC control loop reads to pick the next gain. Gain and offset changes take effect only on window boundaries, so every statistics window uses exactly one gain setting.

## Interface
Parameters:
- WIN_BITS, 20, width of window length in beats
- ACC_BITS, 48, sum-of-squares accumulator/output width

Ports:
- aclk  in  1  stream clock; sole clock
- areset  in  1  asynchronous active-high reset
- s_axis_tdata  in  128  sample k in bits [16k+15:16k], k=0..7
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  128  processed samples, same packing
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- gain_i  in  16  unsigned Q4.12 gain (0x1000 = 1.0)
- offset_i  in  16  signed offset, output LSBs
- update_i  in  1  pulse: capture gain_i/offset_i as pending
- window_len_i  in  WIN_BITS  beats per window; 0 treated as 1
- sq_sum_o  out  ACC_BITS  last completed window sum of squares
- sat_count_o  out  24  last completed window saturated-sample count
- stats_valid_o  out  1  one-cycle pulse when sq_sum_o/sat_count_o update

## Operation
- Three-stage pipeline, global stall: advance = !m_axis_tvalid || m_axis_tready; s_axis_tready = advance. Beat accepted on s_axis_tvalid && s_axis_tready.
- S1: p = x × gain (signed 16 × unsigned 16 → signed 33).
- S2: q = p + (offset << 12) + 2048; r = q >>> 12 (round half toward +inf).
- S3: saturate r to [-32768, 32767]; flag sample saturated if clamped. Register to m_axis_tdata.
- Window counter counts accepted input beats, 0..max(window_len_i,1)-1; window_len_i sampled when counter is 0. Beat where counter hits last value tagged "last"; tag travels with beat.
- Gain/offset: update_i loads pending registers. Active registers load from pending when first beat of a window is accepted (counter == 0 and accept). update_i in that same cycle: new values used for that beat.
- Stats computed on output handshake: s = out_sample >>> 4 (signed 12-bit), add Σ s² over 8 samples to accumulator; add count of saturated samples. On tagged beat handshake: outputs latch accumulator including that beat, stats_valid_o = 1 for one cycle, accumulators clear.
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, sq_sum_o 0, sat_count_o 0, stats_valid_o 0, active/pending gain 0x1000, offset 0, window counter 0, pipeline empty. Reset mid-operation: in-flight beats and partial window discarded, no stats pulse.

## Timing
- Latency: input accept to m_axis_tvalid = 3 cycles, unstalled; throughput 1 beat/cycle.
- m_axis_tdata stable while m_axis_tvalid && !m_axis_tready.
- stats_valid_o asserts the cycle after the tagged beat's output handshake.
- window_len_i = 1: every beat tagged, stats every beat.
- Accumulator cannot overflow: max 2^22 × 8 × 2^20 < 2^48.

## Configuration
- AGC_SAT_COUNT_EN defined: saturation flags and 24-bit counter built; sat_count_o reports count.
- Undefined: no saturation flag/counter logic; sat_count_o tied 0; saturation clamping itself unchanged.

## Test plan
- Gain 0x1000, offset 0, ramp input: output equals input, first m_axis_tvalid exactly 3 cycles after first accept.
- Gain 0x2000, samples 0x5000 and 0xB000 (others 0): outputs 0x7FFF and 0x8000; with AGC_SAT_COUNT_EN, window_len 1 → sat_count_o = 2.
- Gain 0x0800, samples 3 and -3: outputs 2 and -1; offset 5 with gain 0x1000, sample 10 → 15.
- window_len 4, all samples 0x0100, gain 1.0: stats_valid_o every 4 beats, sq_sum_o = 8192.
- m_axis_tready low 5 cycles mid-stream, input valid continuously: s_axis_tready low, no beat lost/duplicated, order preserved.
- update_i gain 0x2000 at beat 2 of window_len 4: beats 2–3 use 1.0, beat 4 onward doubled; sq_sum_o of second window = 4× first.
